// File: rtl/mem_mgmt_unit_if.sv
// Request/response handshake between the two requesters (instruction fetcher,
// load/store path) and the memory management unit that answers them.
interface mem_mgmt_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  valid_from_inst_fetcher;
    logic [ADDR_WIDTH-1:0] addr_from_inst_fetcher;
    logic                  ready_to_inst_fetcher;
    logic [DATA_WIDTH-1:0] inst_to_inst_fetcher;

    logic                  valid_from_load_store;
    logic                  wr_from_load_store;
    logic [2:0]            size_from_load_store;
    logic [ADDR_WIDTH-1:0] addr_from_load_store;
    logic [DATA_WIDTH-1:0] data_from_load_store;
    logic                  ready_to_load_store;
    logic [DATA_WIDTH-1:0] data_to_load_store;

    modport master (
        output valid_from_inst_fetcher, addr_from_inst_fetcher,
        input  ready_to_inst_fetcher, inst_to_inst_fetcher,
        output valid_from_load_store, wr_from_load_store, size_from_load_store,
        output addr_from_load_store, data_from_load_store,
        input  ready_to_load_store, data_to_load_store
    );

    modport slave (
        input  valid_from_inst_fetcher, addr_from_inst_fetcher,
        output ready_to_inst_fetcher, inst_to_inst_fetcher,
        input  valid_from_load_store, wr_from_load_store, size_from_load_store,
        input  addr_from_load_store, data_from_load_store,
        output ready_to_load_store, data_to_load_store
    );
endinterface

// File: rtl/mem_mgmt_unit.sv
// Owner of the byte-wide unified RAM port: serialises word fetches and 1/2/4-byte
// loads/stores into single-byte RAM accesses, assembling little-endian results.
module mem_mgmt_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    mem_mgmt_unit_if.slave        bus
);

    typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  ready_if_q, ready_if_d;
    logic                  ready_ls_q, ready_ls_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  stall_q, stall_d;
    logic [7:0]            stash_q, stash_d;

    logic [7:0]            rd_byte;
    logic [ADDR_WIDTH-1:0] byte_off;
    logic [1:0]            cap_idx;

    function automatic logic [2:0] size_to_len(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // The RAM keeps reading while rdy is low, so the byte in flight when a freeze
    // begins is stashed and used in place of mem_din on the first enabled edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        ready_if_d = ready_if_q;
        ready_ls_d = ready_ls_q;
        inst_d     = inst_q;
        data_d     = data_q;
        stall_d    = stall_q;
        stash_d    = stash_q;
        rd_byte    = stall_q ? stash_q : mem_din;
        byte_off   = {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
        cap_idx    = cnt_q[1:0] - 2'd2;

        if (!rdy) begin
            if (!stall_q) begin
                stall_d = 1'b1;
                stash_d = mem_din;
            end
        end else begin
            stall_d    = 1'b0;
            ready_if_d = 1'b0;
            ready_ls_d = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = 3'd1;
                    buf_d = '0;
                    if (bus.valid_from_load_store) begin
                        addr_d  = bus.addr_from_load_store;
                        len_d   = size_to_len(bus.size_from_load_store);
                        wdata_d = bus.data_from_load_store;
                        mem_a_d = bus.addr_from_load_store;
                        if (bus.wr_from_load_store) begin
                            state_d    = DWRITE;
                            mem_dout_d = bus.data_from_load_store[7:0];
                            mem_wr_d   = 1'b1;
                        end else begin
                            state_d  = DREAD;
                            mem_wr_d = 1'b0;
                        end
                    end else if (bus.valid_from_inst_fetcher) begin
                        state_d  = IFETCH;
                        addr_d   = bus.addr_from_inst_fetcher;
                        len_d    = 3'd4;
                        mem_a_d  = bus.addr_from_inst_fetcher;
                        mem_wr_d = 1'b0;
                    end
                end
                IFETCH, DREAD: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < len_q) begin
                        mem_a_d = addr_q + byte_off;
                    end
                    if (cnt_q >= 3'd2) begin
                        buf_d[{cap_idx, 3'b000} +: 8] = rd_byte;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = DONE;
                        if (state_q == IFETCH) begin
                            inst_d     = buf_d;
                            ready_if_d = 1'b1;
                        end else begin
                            data_d     = buf_d;
                            ready_ls_d = 1'b1;
                        end
                    end
                end
                DWRITE: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < len_q) begin
                        mem_a_d    = addr_q + byte_off;
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                    end else begin
                        mem_wr_d   = 1'b0;
                        ready_ls_d = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            ready_if_q <= 1'b0;
            ready_ls_q <= 1'b0;
            inst_q     <= '0;
            data_q     <= '0;
            stall_q    <= 1'b0;
            stash_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            ready_if_q <= ready_if_d;
            ready_ls_q <= ready_ls_d;
            inst_q     <= inst_d;
            data_q     <= data_d;
            stall_q    <= stall_d;
            stash_q    <= stash_d;
        end
    end

    assign mem_a                    = mem_a_q;
    assign mem_dout                 = mem_dout_q;
    assign mem_wr                   = mem_wr_q & rdy;
    assign bus.ready_to_inst_fetcher = ready_if_q & rdy;
    assign bus.ready_to_load_store   = ready_ls_q & rdy;
    assign bus.inst_to_inst_fetcher  = inst_q;
    assign bus.data_to_load_store    = data_q;

endmodule

// File: tb/tb_mem_mgmt_unit.sv
// Directed bench for mem_mgmt_unit: byte-serial fetches, loads and stores against a
// synchronous-read byte RAM model, plus arbitration, rdy freeze and mid-store reset.
module tb_mem_mgmt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ram_init;
    logic [7:0]  ram [0:511];

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;
    int hold_errs = 0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] prev_inst;
    logic [31:0] prev_data;

    mem_mgmt_unit_if bus_if ();

    mem_mgmt_unit dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Byte RAM: read data appears the cycle after the address, writes land on the edge.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'hAA;
            ram[9'h000] <= 8'h13; ram[9'h001] <= 8'h05; ram[9'h002] <= 8'h00; ram[9'h003] <= 8'h00;
            ram[9'h004] <= 8'h93; ram[9'h005] <= 8'h00; ram[9'h006] <= 8'h10; ram[9'h007] <= 8'h00;
            ram[9'h008] <= 8'h13; ram[9'h009] <= 8'h01; ram[9'h00A] <= 8'h20; ram[9'h00B] <= 8'h00;
            ram[9'h010] <= 8'hB7; ram[9'h011] <= 8'h12; ram[9'h012] <= 8'h34; ram[9'h013] <= 8'h56;
            ram[9'h020] <= 8'hCD; ram[9'h021] <= 8'hAB; ram[9'h022] <= 8'hFF; ram[9'h023] <= 8'hEE;
        end else begin
            if (mem_wr) ram[mem_a[8:0]] <= mem_dout;
            mem_din <= ram[mem_a[8:0]];
        end
    end

    always @(posedge clk) rst_at_edge <= rst;

    // Output words may only change on their own ready pulse or through reset.
    always @(negedge clk) begin
        if (mem_wr) wr_cycles++;
        if (!rst_at_edge && !bus_if.ready_to_inst_fetcher && bus_if.inst_to_inst_fetcher !== prev_inst)
            hold_errs++;
        if (!rst_at_edge && !bus_if.ready_to_load_store && bus_if.data_to_load_store !== prev_data)
            hold_errs++;
        prev_inst = bus_if.inst_to_inst_fetcher;
        prev_data = bus_if.data_to_load_store;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vf, input logic [31:0] af, input logic vl, input logic wl,
                                 input logic [2:0] sl, input logic [31:0] al, input logic [31:0] dl);
        bus_if.valid_from_inst_fetcher = vf;
        bus_if.addr_from_inst_fetcher  = af;
        bus_if.valid_from_load_store   = vl;
        bus_if.wr_from_load_store      = wl;
        bus_if.size_from_load_store    = sl;
        bus_if.addr_from_load_store    = al;
        bus_if.data_from_load_store    = dl;
    endtask

    task automatic waitReady(input logic is_fetch, input string tag, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            seen = is_fetch ? bus_if.ready_to_inst_fetcher : bus_if.ready_to_load_store;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        int n2;
        int wr0;
        int ready_seen;
        logic [7:0] exp_b [4];

        rst = 1'b1;
        rdy = 1'b1;
        ram_init = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        ram_init = 1'b0;
        checkOutput("reset mem_a", mem_a, 0);
        checkOutput("reset mem_dout", 32'(mem_dout), 0);
        checkOutput("reset mem_wr", 32'(mem_wr), 0);
        checkOutput("reset ready_if", 32'(bus_if.ready_to_inst_fetcher), 0);
        checkOutput("reset ready_ls", 32'(bus_if.ready_to_load_store), 0);
        checkOutput("reset inst", bus_if.inst_to_inst_fetcher, 0);
        checkOutput("reset data", bus_if.data_to_load_store, 0);
        rst = 1'b0;
        step();

        $display("[TB] fetch at 0x0");
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
        step();
        checkOutput("f0 mem_a k0", mem_a, 32'h0);
        checkOutput("f0 mem_wr", 32'(mem_wr), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            checkOutput($sformatf("f0 mem_a k%0d", k), mem_a, 32'(k));
            checkOutput($sformatf("f0 early ready k%0d", k), 32'(bus_if.ready_to_inst_fetcher), 0);
        end
        waitReady(1, "f0 ready seen", n);
        checkOutput("f0 latency", 32'(3 + n), 5);
        checkOutput("f0 inst", bus_if.inst_to_inst_fetcher, 32'h00000513);
        step();
        checkOutput("f0 pulse width", 32'(bus_if.ready_to_inst_fetcher), 0);

        $display("[TB] back-to-back fetches 0x4, 0x8");
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
        waitReady(1, "f4 ready seen", n);
        checkOutput("f4 latency", 32'(n), 5);
        checkOutput("f4 inst", bus_if.inst_to_inst_fetcher, 32'h00100093);
        step();
        checkOutput("f8 not accepted in DONE", mem_a, 32'h7);
        checkOutput("f4 pulse width", 32'(bus_if.ready_to_inst_fetcher), 0);
        step();
        checkOutput("f8 accept mem_a", mem_a, 32'h8);
        waitReady(1, "f8 ready seen", n2);
        // Six idle cycles separate the two pulses, so the pulses start 7 edges apart.
        checkOutput("fetch pulse spacing", 32'(2 + n2), 7);
        checkOutput("f8 inst", bus_if.inst_to_inst_fetcher, 32'h00200113);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] simultaneous fetch 0x10 and 2-byte load 0x20");
        applyStimulus(1, 32'h10, 1, 0, 3'd2, 32'h20, 0);
        step();
        checkOutput("arb load first", mem_a, 32'h20);
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
        waitReady(0, "ld ready seen", n);
        checkOutput("ld latency", 32'(n), 3);
        checkOutput("ld data", bus_if.data_to_load_store, 32'h0000ABCD);
        checkOutput("ld no fetch ready", 32'(bus_if.ready_to_inst_fetcher), 0);
        checkOutput("ld inst held", bus_if.inst_to_inst_fetcher, 32'h00200113);
        step();
        step();
        checkOutput("f10 accept after DONE", mem_a, 32'h10);
        waitReady(1, "f10 ready seen", n);
        checkOutput("f10 latency", 32'(n), 5);
        checkOutput("f10 inst", bus_if.inst_to_inst_fetcher, 32'h563412B7);
        checkOutput("f10 data held", bus_if.data_to_load_store, 32'h0000ABCD);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] 4-byte store 0xDEADBEEF at 0x100");
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        wr0 = wr_cycles;
        applyStimulus(0, 0, 1, 1, 3'd4, 32'h100, 32'hDEADBEEF);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            checkOutput($sformatf("st mem_a k%0d", k), mem_a, 32'h100 + 32'(k));
            checkOutput($sformatf("st mem_dout k%0d", k), 32'(mem_dout), 32'(exp_b[k]));
            checkOutput($sformatf("st mem_wr k%0d", k), 32'(mem_wr), 1);
        end
        step();
        checkOutput("st ready at E4", 32'(bus_if.ready_to_load_store), 1);
        checkOutput("st mem_wr off at E4", 32'(mem_wr), 0);
        step();
        checkOutput("st pulse width", 32'(bus_if.ready_to_load_store), 0);
        checkOutput("st mem_wr cycles", 32'(wr_cycles - wr0), 4);
        checkOutput("st ram word", {ram[9'h103], ram[9'h102], ram[9'h101], ram[9'h100]}, 32'hDEADBEEF);
        checkOutput("st data unchanged", bus_if.data_to_load_store, 32'h0000ABCD);

        $display("[TB] fetch 0x8 with rdy low for 3 cycles");
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        checkOutput("stall mem_a before", mem_a, 32'hA);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("stall mem_a c%0d", k), mem_a, 32'hA);
            checkOutput($sformatf("stall mem_wr c%0d", k), 32'(mem_wr), 0);
            checkOutput($sformatf("stall ready c%0d", k), 32'(bus_if.ready_to_inst_fetcher), 0);
        end
        rdy = 1'b1;
        waitReady(1, "stall ready seen", n);
        checkOutput("stall latency", 32'(2 + 3 + n), 8);
        checkOutput("stall inst", bus_if.inst_to_inst_fetcher, 32'h00200113);
        step();
        checkOutput("stall pulse width", 32'(bus_if.ready_to_inst_fetcher), 0);

        $display("[TB] reset after 2 bytes of a store");
        applyStimulus(0, 0, 1, 1, 3'd4, 32'h104, 32'h11223344);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst mem_a", mem_a, 0);
        checkOutput("rst mem_dout", 32'(mem_dout), 0);
        checkOutput("rst mem_wr", 32'(mem_wr), 0);
        checkOutput("rst ready_ls", 32'(bus_if.ready_to_load_store), 0);
        checkOutput("rst inst", bus_if.inst_to_inst_fetcher, 0);
        checkOutput("rst data", bus_if.data_to_load_store, 0);
        ready_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus_if.ready_to_load_store || mem_wr) ready_seen++;
        end
        checkOutput("rst no ready or write", 32'(ready_seen), 0);
        checkOutput("rst ram 0x104", 32'(ram[9'h104]), 32'h44);
        checkOutput("rst ram 0x105", 32'(ram[9'h105]), 32'h33);
        checkOutput("rst ram 0x106", 32'(ram[9'h106]), 32'hAA);
        checkOutput("rst ram 0x107", 32'(ram[9'h107]), 32'hAA);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitReady(1, "post-rst ready seen", n);
        checkOutput("post-rst latency", 32'(n), 5);
        checkOutput("post-rst inst", bus_if.inst_to_inst_fetcher, 32'h00000513);
        step();

        checkOutput("output words held", 32'(hold_errs), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
